// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, constants and opcode decode for the ALU operand stage
// Purpose: operand/opcode widths, opcode enum, one-hot unit selects, beat struct,
//          and the opcode-to-unit-select decode used by the issue stage.
// Ports: none (package).
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 3;
    localparam int ALU_SELW  = 6;

    typedef enum logic [ALU_OPW-1:0] {
        OP_NOT = 3'd0,
        OP_AND = 3'd1,
        OP_OR  = 3'd2,
        OP_XOR = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5
    } alu_op_e;

    localparam logic [ALU_SELW-1:0] SEL_NOT  = 6'b000001;
    localparam logic [ALU_SELW-1:0] SEL_AND  = 6'b000010;
    localparam logic [ALU_SELW-1:0] SEL_OR   = 6'b000100;
    localparam logic [ALU_SELW-1:0] SEL_XOR  = 6'b001000;
    localparam logic [ALU_SELW-1:0] SEL_ADD  = 6'b010000;
    localparam logic [ALU_SELW-1:0] SEL_SUB  = 6'b100000;
    localparam logic [ALU_SELW-1:0] SEL_NONE = 6'b000000;

    typedef struct packed {
        logic [ALU_OPW-1:0]   op;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_beat_t;

    // Opcodes 6 and 7 have no unit; they decode to an all-zero select.
    function automatic logic [ALU_SELW-1:0] alu_decode_sel(input logic [ALU_OPW-1:0] op);
        logic [ALU_SELW-1:0] sel;
        case (op)
            OP_NOT:  sel = SEL_NOT;
            OP_AND:  sel = SEL_AND;
            OP_OR:   sel = SEL_OR;
            OP_XOR:  sel = SEL_XOR;
            OP_ADD:  sel = SEL_ADD;
            OP_SUB:  sel = SEL_SUB;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - upstream/downstream handshake bundle of the ALU operand stage
// Purpose: groups flush, the input beat handshake and the presented operation.
// Modports: slave  - the operand stage (consumes in_*, drives out_*)
//           master - the driver/observer side (drives in_*, out_ready, flush)
interface alu_operand_stage_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [OPW-1:0]   out_op;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [5:0]       out_sel;
    logic             out_illegal;

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_op, out_a, out_b, out_sel, out_illegal
    );

    modport master (
        output flush, in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_op, out_a, out_b, out_sel, out_illegal
    );
endinterface

// File: rtl/alu_skid_buf.sv
// rtl/alu_skid_buf.sv - generic 2-entry valid/ready skid buffer
// Purpose: registered main entry drives the output; a skid entry absorbs one beat
//          when the output stalls, so in_ready depends on registers only.
// Ports: clk, rst_n (async active-low), flush (sync clear of both entries),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
module alu_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    logic          main_valid;
    logic          skid_valid;
    logic [DW-1:0] main_data;
    logic [DW-1:0] skid_data;
    logic          accept;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Data registers are reset too so the presented fields read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end
        end else if (out_ready) begin
            // Oldest waiting beat refills main; skid full implies no accept this cycle.
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered operand issue stage ahead of the ALU function units
// Purpose: buffers {op, a, b} beats in a 2-entry skid buffer, pre-decodes the one-hot
//          unit select and illegal flag, handles flush and post-reset ready gating.
// Ports: clk, rst_n (async active-low), bus (alu_operand_stage_if.slave: flush,
//        in_valid/in_ready/in_op/in_a/in_b, out_valid/out_ready/out_op/out_a/out_b/
//        out_sel/out_illegal).
// Optional: ALU_OPERAND_STAT_EN adds stat_issued and stat_stall 32-bit counters.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_stage_if.slave   bus
`ifdef ALU_OPERAND_STAT_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);
    typedef struct packed {
        logic             illegal;
        logic [5:0]       sel;
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } issue_t;

    logic   ready_q;
    logic   buf_in_valid;
    logic   buf_in_ready;
    logic   buf_out_valid;
    logic   in_ready_w;
    issue_t in_issue;
    issue_t out_issue;

    // Holds off acceptance for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign in_ready_w   = ready_q & buf_in_ready;
    assign buf_in_valid = bus.in_valid & ready_q;
    assign bus.in_ready = in_ready_w;

    // Decode happens on the way in so sel/illegal are registered alongside the opcode.
    always_comb begin
        in_issue.sel     = alu_decode_sel(bus.in_op);
        in_issue.illegal = (in_issue.sel == SEL_NONE);
        in_issue.op      = bus.in_op;
        in_issue.a       = bus.in_a;
        in_issue.b       = bus.in_b;
    end

    alu_skid_buf #(
        .DW($bits(issue_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (in_issue),
        .out_valid (buf_out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_issue)
    );

    assign bus.out_valid   = buf_out_valid;
    assign bus.out_op      = out_issue.op;
    assign bus.out_a       = out_issue.a;
    assign bus.out_b       = out_issue.b;
    // The main entry may hold a stale decode once drained; mask it with the valid.
    assign bus.out_sel     = buf_out_valid ? out_issue.sel : SEL_NONE;
    assign bus.out_illegal = buf_out_valid & out_issue.illegal;

`ifdef ALU_OPERAND_STAT_EN
    // Counters ignore flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (buf_out_valid & bus.out_ready)
                stat_issued <= stat_issued + 32'd1;
            if (bus.in_valid & ~in_ready_w)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif
endmodule
